// File: rtl/sr_ignition_if.sv
// ============================================================================
// Module  : sr_ignition_if
// Brief   : Control and status bundle between the SR ignition controller and
//           its neighbours (alignment detector upstream, coupling stage down).
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sr_ignition_if #(
    parameter int WIDTH = 18
);
    logic                    clk_en;
    logic                    enable;
    logic signed [WIDTH-1:0] ignition_sensitivity;
    logic                    sr_event;
    logic [2:0]              state;
    logic                    armed;
    logic                    ignition_active;
    logic                    ignition_start;
    logic signed [WIDTH-1:0] ignition_gain;
    logic [15:0]             ignition_count;

    modport master (
        output clk_en, enable, ignition_sensitivity, sr_event,
        input  state, armed, ignition_active, ignition_start,
               ignition_gain, ignition_count
    );

    modport slave (
        input  clk_en, enable, ignition_sensitivity, sr_event,
        output state, armed, ignition_active, ignition_start,
               ignition_gain, ignition_count
    );
endinterface

`default_nettype wire

// File: rtl/sr_ignition_controller.sv
// ============================================================================
// Module  : sr_ignition_controller
// Brief   : Arms on sustained ignition sensitivity, fires a fixed ignition
//           window on the next SR event, then holds off for a refractory time.
//           Optional macro IGNITION_ENVELOPE_EN turns the gain into a ramp.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module sr_ignition_controller #(
    parameter int WIDTH         = 18,
    parameter int FRAC          = 14,
    parameter int ARM_THRESH    = 8192,
    parameter int DISARM_THRESH = 6554,
    parameter int DWELL_TICKS   = 4,
    parameter int IGNITE_TICKS  = 8,
    parameter int REFRACT_TICKS = 16,
    parameter int RAMP_STEP     = 4096
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    sr_ignition_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ARMING  = 3'd1;
    localparam logic [2:0] S_ARMED   = 3'd2;
    localparam logic [2:0] S_IGNITE  = 3'd3;
    localparam logic [2:0] S_REFRACT = 3'd4;

    localparam logic signed [WIDTH-1:0] ONE        = (WIDTH)'(1 << FRAC);
    localparam logic signed [WIDTH-1:0] ARM_T      = (WIDTH)'(ARM_THRESH);
    localparam logic signed [WIDTH-1:0] DISARM_T   = (WIDTH)'(DISARM_THRESH);
    localparam logic [15:0]             DWELL_LAST = 16'(DWELL_TICKS - 1);
    localparam logic [15:0]             IGN_LAST   = 16'(IGNITE_TICKS - 1);
    localparam logic [15:0]             REF_LAST   = 16'(REFRACT_TICKS - 1);

    // Marker block: only present in the hierarchy for an illegal parameter set.
    if (DISARM_THRESH > ARM_THRESH || DWELL_TICKS < 1 || IGNITE_TICKS < 1 ||
        REFRACT_TICKS < 1 || DWELL_TICKS > 65535 || IGNITE_TICKS > 65535 ||
        REFRACT_TICKS > 65535 || RAMP_STEP < 0) begin : g_illegal_params
    end

    logic [2:0]              state_q, state_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [15:0]             count_q, count_d;
    logic                    armed_q, armed_d;
    logic                    active_q, active_d;
    logic                    start_q, start_d;
    logic signed [WIDTH-1:0] gain_q, gain_d;

    logic w_tick;
    logic w_arm;
    logic w_disarm;

    assign w_tick   = bus.clk_en;
    assign w_arm    = bus.enable && ($signed(bus.ignition_sensitivity) >= ARM_T);
    assign w_disarm = !bus.enable || ($signed(bus.ignition_sensitivity) < DISARM_T);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            count_q  <= '0;
            armed_q  <= 1'b0;
            active_q <= 1'b0;
            start_q  <= 1'b0;
            gain_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            count_q  <= count_d;
            armed_q  <= armed_d;
            active_q <= active_d;
            start_q  <= start_d;
            gain_q   <= gain_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        if (w_tick) begin
            case (state_q)
                S_IDLE: begin
                    if (w_arm) begin
                        state_d = S_ARMING;
                        cnt_d   = '0;
                    end
                end
                S_ARMING: begin
                    if (w_disarm) begin
                        state_d = S_IDLE;
                    end else if (cnt_q == DWELL_LAST) begin
                        state_d = S_ARMED;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_ARMED: begin
                    // An SR event wins over a simultaneous disarm condition.
                    if (bus.sr_event) begin
                        state_d = S_IGNITE;
                        cnt_d   = '0;
                        count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
                    end else if (w_disarm) begin
                        state_d = S_IDLE;
                    end
                end
                S_IGNITE: begin
                    if (cnt_q == IGN_LAST) begin
                        state_d = S_REFRACT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                S_REFRACT: begin
                    if (cnt_q == REF_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef IGNITION_ENVELOPE_EN
    localparam logic signed [WIDTH:0] ONE_X  = (WIDTH+1)'(1 << FRAC);
    localparam logic signed [WIDTH:0] RAMP_X = (WIDTH+1)'(RAMP_STEP);

    logic signed [WIDTH:0] w_gain_up;
    logic signed [WIDTH:0] w_gain_dn;

    assign w_gain_up = {gain_q[WIDTH-1], gain_q} + RAMP_X;
    assign w_gain_dn = {gain_q[WIDTH-1], gain_q} - RAMP_X;
`endif

    always_comb begin
        armed_d  = (state_d == S_ARMED);
        active_d = (state_d == S_IGNITE);
        start_d  = (state_q == S_ARMED) && (state_d == S_IGNITE);
`ifdef IGNITION_ENVELOPE_EN
        // Ramp follows the state the tick was spent in, not the one entered.
        gain_d = gain_q;
        if (w_tick) begin
            if (state_q == S_IGNITE) begin
                gain_d = (w_gain_up >= ONE_X) ? ONE : w_gain_up[WIDTH-1:0];
            end else begin
                gain_d = (w_gain_dn < 0) ? '0 : w_gain_dn[WIDTH-1:0];
            end
        end
`else
        gain_d = active_d ? ONE : '0;
`endif
    end

    assign bus.state           = state_q;
    assign bus.armed           = armed_q;
    assign bus.ignition_active = active_q;
    assign bus.ignition_start  = start_q;
    assign bus.ignition_gain   = gain_q;
    assign bus.ignition_count  = count_q;

endmodule

`default_nettype wire

// File: tb/tb_sr_ignition_controller.sv
// ============================================================================
// Module  : tb_sr_ignition_controller
// Brief   : Directed scoreboard bench: stimulus queues expected state entries,
//           a negedge monitor pops and compares on every state change.
// Rev     : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sr_ignition_controller;

    localparam int ST_IDLE = 0, ST_ARMING = 1, ST_ARMED = 2, ST_IGNITE = 3, ST_REFRACT = 4;
`ifdef IGNITION_ENVELOPE_EN
    localparam int G_IGN_ENTRY = 0;
    localparam int G_REF_ENTRY = 16384;
`else
    localparam int G_IGN_ENTRY = 16384;
    localparam int G_REF_ENTRY = 0;
`endif

    typedef struct {
        int st;
        int armed;
        int act;
        int start;
        int gain;
        int cnt;
        int dwell;
    } exp_t;

    logic clk;
    logic rst_n;
    bit   half;

    exp_t q[$];
    int   gq[$];
    exp_t e;
    int   n_checks;
    int   n_err;
    int   cyc;
    int   last_cyc;
    int   prev_st;
    logic prev_start;
    bit   gtrace;

    sr_ignition_if #(.WIDTH(18)) bus ();

    sr_ignition_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic push(input int st, input int dwell, input int cnt);
        exp_t x;
        x.st    = st;
        x.armed = (st == ST_ARMED) ? 1 : 0;
        x.act   = (st == ST_IGNITE) ? 1 : 0;
        x.start = (st == ST_IGNITE) ? 1 : 0;
        x.gain  = (st == ST_IGNITE) ? G_IGN_ENTRY : (st == ST_REFRACT) ? G_REF_ENTRY : 0;
        x.cnt   = cnt;
        x.dwell = dwell;
        q.push_back(x);
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (half) bus.clk_en = ~bus.clk_en;
        end
    endtask

    // Monitor: one scoreboard pop per observed state change.
    always @(negedge clk) begin
        cyc++;
        if (int'(bus.state) != prev_st) begin
            if (q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_transition: got state %0d from %0d, expected none", bus.state, prev_st);
            end else begin
                e = q.pop_front();
                chk("state", int'(bus.state), e.st);
                chk("armed", int'(bus.armed), e.armed);
                chk("ignition_active", int'(bus.ignition_active), e.act);
                chk("ignition_start", int'(bus.ignition_start), e.start);
                chk("ignition_gain", int'($signed(bus.ignition_gain)), e.gain);
                chk("ignition_count", int'(bus.ignition_count), e.cnt);
                if (e.dwell >= 0) chk("dwell_clks", cyc - last_cyc, e.dwell);
            end
            last_cyc = cyc;
            prev_st  = int'(bus.state);
        end
        if (prev_start) chk("start_width", int'(bus.ignition_start), 0);
        if (gtrace) begin
            chk("gain_trace", int'($signed(bus.ignition_gain)), gq.pop_front());
            if (gq.size() == 0) gtrace = 1'b0;
        end
        if (bus.ignition_start && gq.size() > 0) gtrace = 1'b1;
        prev_start = bus.ignition_start;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        clk = 1'b0; rst_n = 1'b0; half = 1'b0;
        n_checks = 0; n_err = 0; cyc = 0; last_cyc = 0; prev_st = 0;
        prev_start = 1'b0; gtrace = 1'b0;
        bus.clk_en = 1'b1; bus.enable = 1'b1;
        bus.ignition_sensitivity = 18'sd12000; bus.sr_event = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", int'(bus.state), 0);
        chk("reset_armed", int'(bus.armed), 0);
        chk("reset_active", int'(bus.ignition_active), 0);
        chk("reset_start", int'(bus.ignition_start), 0);
        chk("reset_gain", int'($signed(bus.ignition_gain)), 0);
        chk("reset_count", int'(bus.ignition_count), 0);

        // Basic arm / ignite / refract sequence
        push(ST_ARMING, -1, 0); push(ST_ARMED, 4, 0); push(ST_IGNITE, 2, 1);
        push(ST_REFRACT, 8, 1); push(ST_IDLE, 16, 1); push(ST_ARMING, 1, 1);
`ifdef IGNITION_ENVELOPE_EN
        gq = '{4096, 8192, 12288, 16384, 16384, 16384, 16384, 16384, 12288, 8192, 4096, 0};
`else
        gq = '{16384, 16384, 16384, 16384, 16384, 16384, 16384, 0, 0, 0, 0, 0};
`endif
        rst_n = 1'b1;
        cycles(6);  bus.sr_event = 1'b1;
        cycles(1);  bus.sr_event = 1'b0;
        cycles(25);

        // Hysteresis and threshold boundaries
        push(ST_ARMED, 4, 1); push(ST_IDLE, 1, 1); push(ST_ARMING, 1, 1);
        push(ST_IDLE, 1, 1); push(ST_ARMING, 1, 1); push(ST_IDLE, 2, 1);
        bus.ignition_sensitivity = 18'sd7000;   cycles(4);
        bus.ignition_sensitivity = 18'sd5000;   cycles(1);
        bus.ignition_sensitivity = 18'sd12000;  cycles(1);
        bus.ignition_sensitivity = 18'sd5000;   cycles(1);
        bus.ignition_sensitivity = 18'sd8192;   cycles(1);
        bus.ignition_sensitivity = 18'sd6554;   cycles(1);
        bus.ignition_sensitivity = -18'sd32768; cycles(1);
        bus.ignition_sensitivity = 18'sd8191;   cycles(2);

        // sr_event held high across all states: one ignition per arm cycle
        push(ST_ARMING, 3, 1); push(ST_ARMED, 4, 1); push(ST_IGNITE, 1, 2);
        push(ST_REFRACT, 8, 2); push(ST_IDLE, 16, 2); push(ST_ARMING, 1, 2);
        push(ST_ARMED, 4, 2); push(ST_IGNITE, 1, 3); push(ST_REFRACT, 8, 3);
        push(ST_IDLE, 16, 3);
        bus.ignition_sensitivity = 18'sd12000; bus.sr_event = 1'b1;
        cycles(36);
        bus.sr_event = 1'b0; bus.enable = 1'b0;
        cycles(24);

        // sr_event beats disarm in ARMED; enable drop in ARMED disarms
        push(ST_ARMING, 1, 3); push(ST_ARMED, 4, 3); push(ST_IGNITE, 1, 4);
        push(ST_REFRACT, 8, 4); push(ST_IDLE, 16, 4); push(ST_ARMING, 1, 4);
        push(ST_ARMED, 4, 4); push(ST_IDLE, 1, 4);
        bus.enable = 1'b1; cycles(5);
        bus.ignition_sensitivity = 18'sd0; bus.sr_event = 1'b1; cycles(1);
        bus.sr_event = 1'b0; bus.ignition_sensitivity = 18'sd12000; cycles(29);
        bus.enable = 1'b0; cycles(2);

        // clk_en every other clk doubles every duration
        push(ST_ARMING, 2, 4); push(ST_ARMED, 8, 4); push(ST_IGNITE, 2, 5);
        push(ST_REFRACT, 16, 5); push(ST_IDLE, 32, 5);
        half = 1'b1; bus.enable = 1'b1; bus.clk_en = 1'b1;
        cycles(9);  bus.sr_event = 1'b1;
        cycles(2);  bus.sr_event = 1'b0;
        cycles(48);

        // Asynchronous reset in the middle of an ignition window
        push(ST_ARMING, 1, 5); push(ST_ARMED, 4, 5); push(ST_IGNITE, 1, 6);
        push(ST_IDLE, -1, 0); push(ST_ARMING, -1, 0);
        half = 1'b0; bus.clk_en = 1'b1;
        cycles(5);  bus.sr_event = 1'b1;
        cycles(1);  bus.sr_event = 1'b0;
        cycles(2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_state", int'(bus.state), 0);
        chk("async_rst_active", int'(bus.ignition_active), 0);
        chk("async_rst_gain", int'($signed(bus.ignition_gain)), 0);
        chk("async_rst_count", int'(bus.ignition_count), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int i = 0; i < 50 && q.size() > 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        chk("scoreboard_drained", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sr_ignition_controller.md
Name: sr_ignition_controller

Overview:
Sequences SR ignition events from the ignition_sensitivity metric of the phi^n alignment detector. Requires sensitivity to stay above an arm threshold for a dwell time. Fires a fixed-length ignition window on the next external SR event, then enforces a refractory period. Sits between the alignment detector and the oscillator coupling stage that consumes ignition_gain.

Parameters:
WIDTH, 18, datapath width (Q14 signed)
FRAC, 14, fractional bits
ARM_THRESH, 8192, sensitivity at or above which arming starts (0.5 Q14)
DISARM_THRESH, 6554, sensitivity below which arming aborts (0.4 Q14); must be <= ARM_THRESH
DWELL_TICKS, 4, clk_en ticks spent in ARMING before ARMED; >= 1
IGNITE_TICKS, 8, clk_en ticks spent in IGNITE; >= 1
REFRACT_TICKS, 16, clk_en ticks spent in REFRACT; >= 1
RAMP_STEP, 4096, envelope increment per tick (used only with the optional feature)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
clk_en  in  1  update tick; all state and counters advance only when high
enable  in  1  controller enable
ignition_sensitivity  in  WIDTH signed  Q14 sensitivity from the alignment detector
sr_event  in  1  SR event strobe, sampled on ticks
state  out  3  FSM state: IDLE=0, ARMING=1, ARMED=2, IGNITE=3, REFRACT=4
armed  out  1  high while state==ARMED
ignition_active  out  1  high while state==IGNITE
ignition_start  out  1  one-clk pulse on IGNITE entry
ignition_gain  out  WIDTH signed  Q14 gain to the coupling stage
ignition_count  out  16  saturating count of ignitions

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; all counters 0; armed, ignition_active, ignition_start=0; ignition_gain=0; ignition_count=0.
- All outputs are registered. They reflect the new state in the cycle after the transition edge.
- clk_en low: FSM, counters and gain are frozen, and sr_event is ignored. ignition_start still clears on the next clk.
- Comparisons are signed. Negative sensitivity is below both thresholds.
- IDLE: if enable and sens >= ARM_THRESH, go to ARMING and clear the tick counter.
- ARMING: if !enable or sens < DISARM_THRESH, go to IDLE. Otherwise increment the counter. When the counter reaches DWELL_TICKS-1 on a tick, go to ARMED. Sensitivity between the two thresholds holds the arming (hysteresis).
- ARMED: sr_event has priority over disarm. If sr_event, go to IGNITE; clear the counter; increment ignition_count (saturate at 65535); pulse ignition_start for one clk. Otherwise, if !enable or sens < DISARM_THRESH, go to IDLE.
- IGNITE: sr_event, sensitivity and enable are all ignored. After IGNITE_TICKS ticks, go to REFRACT and clear the counter.
- REFRACT: sr_event is ignored. After REFRACT_TICKS ticks, go to IDLE. Re-arming is evaluated from IDLE on the following tick.
- sr_event in IDLE, ARMING, IGNITE or REFRACT: no effect, and ignition_count is unchanged.
- Base ignition_gain: ONE (16384) while state==IGNITE, otherwise 0.
- Tick counter is 16 bits. Parameters larger than 65535 are illegal.
- Illegal state encodings return to IDLE on the next tick.

Optional Feature:
IGNITION_ENVELOPE_EN
- Defined: ignition_gain is a ramp register instead of the base step.
  - Each tick in IGNITE, gain += RAMP_STEP, saturating at ONE.
  - Each tick in any other state, gain -= RAMP_STEP, saturating at 0.
  - Reset value is 0.
- Undefined: ignition_gain uses the base step behaviour, and RAMP_STEP is unused.

Test Plan:
1. Defaults, clk_en=1 continuously, sens=12000, sr_event pulsed 2 cycles after ARMED -> ARMING 1 cycle after release, ARMED after 4 ticks, then IGNITE. ignition_start high exactly 1 cycle; ignition_count=1; IGNITE lasts 8 cycles, REFRACT 16, then IDLE, then ARMING again.
2. Hysteresis: in ARMING drop sens to 7000 -> stays ARMING and reaches ARMED. Repeat with sens 5000 -> IDLE next tick; negative sens -32768 -> IDLE.
3. sr_event held high through IDLE, ARMING, IGNITE and REFRACT -> exactly one ignition per arm cycle. ignition_count increments only on ARMED->IGNITE.
4. In ARMED, assert sr_event with sens=0 on the same tick -> IGNITE. Separately, drop enable in ARMED -> IDLE. Drop enable in IGNITE -> window completes its 8 ticks.
5. clk_en high every other clk -> all dwell, ignite and refract durations double in clk cycles, and ignition_start is still 1 clk wide. Assert rst_n low mid-IGNITE -> all outputs 0 immediately, without waiting for a clk edge.
6. With IGNITION_ENVELOPE_EN -> gain 4096, 8192, 12288, 16384 over the first 4 IGNITE ticks, held at 16384, then decays to 0 over 4 REFRACT ticks. Without the macro -> gain steps 0->16384->0 aligned with ignition_active.
